// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = 6;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/mdu_if.sv
// EX-stage <-> MDU bundle. start is a request sampled only while busy=0;
// there is no ready: the hazard unit holds the op until busy drops.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, srca, srcb, mthi, mtlo, wd,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, srca, srcb, mthi, mtlo, wd,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mdu_sign_fix.sv
// Sign handling around the unsigned MDU core: operand magnitudes in,
// sign-corrected product or quotient/remainder out.
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_abs_a,
    output logic [WIDTH-1:0] o_abs_b,
    input  logic             i_is_mul,
    input  logic             i_neg_res,
    input  logic             i_neg_rem,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_neg;

    assign o_abs_a = i_a[WIDTH-1] ? -i_a : i_a;
    assign o_abs_b = i_b[WIDTH-1] ? -i_b : i_b;

    always_comb begin
        w_prod     = {i_hi, i_lo};
        w_prod_neg = -w_prod;
        o_hi       = i_hi;
        o_lo       = i_lo;
        if (i_is_mul) begin
            if (i_neg_res) begin
                {o_hi, o_lo} = w_prod_neg;
            end
        end else begin
            if (i_neg_res) begin
                o_lo = -i_lo;
            end
            if (i_neg_rem) begin
                o_hi = -i_hi;
            end
        end
    end
endmodule

// File: rtl/mdu_controller.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Define MDU_SIGNED_EN to enable signed MULT/DIV; otherwise op[0] is ignored.
module mdu_controller
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = MDU_CNT_W
) (
    input  logic   clk,
    input  logic   reset,
    mdu_if.slave   bus,
    output state_t o_state
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;      // multiplicand or divisor
    logic [WIDTH-1:0] r_b;      // multiplier (shifting out) or dividend/quotient
    logic [WIDTH-1:0] r_acc;    // upper product half or partial remainder
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_last;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_opb;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_sum   = {1'b0, r_acc} + {1'b0, (r_b[0] ? r_a : '0)};
    assign w_shift = {r_acc, r_b[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_a};
    // Remainder stays below the divisor, so bit WIDTH is the trial sign.
    assign w_ge    = ~w_diff[WIDTH];

    always_comb begin
        w_acc_nxt = r_acc;
        w_b_nxt   = r_b;
        if (r_state == MUL) begin
            w_acc_nxt = w_sum[WIDTH:1];
            w_b_nxt   = {w_sum[0], r_b[WIDTH-1:1]};
        end else begin
            w_acc_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            w_b_nxt   = {r_b[WIDTH-2:0], w_ge};
        end
    end

`ifdef MDU_SIGNED_EN
    logic             w_sgn;
    logic             w_neg_a;
    logic             w_neg_b;
    logic             w_div0;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             r_neg_res;
    logic             r_neg_rem;

    assign w_sgn   = ~bus.op[0];
    assign w_neg_a = w_sgn & bus.srca[WIDTH-1];
    assign w_neg_b = w_sgn & bus.srcb[WIDTH-1];
    assign w_div0  = bus.op[1] & (bus.srcb == '0);
    assign w_opa   = w_sgn ? w_abs_a : bus.srca;
    assign w_opb   = w_sgn ? w_abs_b : bus.srcb;

    mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .i_a       (bus.srca),
        .i_b       (bus.srcb),
        .o_abs_a   (w_abs_a),
        .o_abs_b   (w_abs_b),
        .i_is_mul  (r_state == MUL),
        .i_neg_res (r_neg_res),
        .i_neg_rem (r_neg_rem),
        .i_hi      (w_acc_nxt),
        .i_lo      (w_b_nxt),
        .o_hi      (w_res_hi),
        .o_lo      (w_res_lo)
    );

    // Signed divide by zero keeps the raw unsigned-core result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else if (r_state == IDLE && bus.start) begin
            r_neg_res <= (w_neg_a ^ w_neg_b) & ~w_div0;
            r_neg_rem <= w_neg_a & bus.op[1] & ~w_div0;
        end
    end
`else
    logic w_unused_op0;

    assign w_unused_op0 = bus.op[0];
    assign w_opa        = bus.srca;
    assign w_opb        = bus.srcb;
    assign w_res_hi     = w_acc_nxt;
    assign w_res_lo     = w_b_nxt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = bus.op[1] ? DIV : MUL;
            MUL,
            DIV:     if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (bus.start) begin
                    r_a   <= bus.op[1] ? w_opb : w_opa;
                    r_b   <= bus.op[1] ? w_opa : w_opb;
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    if (bus.mthi) r_hi <= bus.wd;
                    if (bus.mtlo) r_lo <= bus.wd;
                end
            end else begin
                r_acc <= w_acc_nxt;
                r_b   <= w_b_nxt;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_hi   <= w_res_hi;
                    r_lo   <= w_res_lo;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = (r_state != IDLE);
    assign bus.done = r_done;
    assign o_state  = r_state;
endmodule

// File: tb/tb_mdu_controller.sv
// Directed bench for mdu_controller: unsigned/signed ops, HI/LO writes,
// busy-time interference and mid-operation reset.
module tb_mdu_controller;
    import mdu_pkg::*;

    localparam int W = 32;

    logic   clk;
    logic   reset;
    state_t dbg_state;
    int     checks;
    int     errors;
    int     cyc;
    int     early;

    mdu_if #(.WIDTH(W)) bus ();

    mdu_controller #(.WIDTH(W), .CNT_W(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .o_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog sim_time_limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.srca  = a;
        bus.srcb  = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int c, output int e);
        c = 0;
        e = 0;
        while (bus.busy && c < 200) begin
            if (bus.done) e++;
            c++;
            @(negedge clk);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.srca  = '0;
        bus.srcb  = '0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wd    = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
        @(negedge clk);

        // MULTU max x max
        start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mul_state", 32'(dbg_state), 32'(MUL));
        wait_done(cyc, early);
        chk("mul_busy_cycles", 32'(cyc), 32'd32);
        chk("mul_done_early", 32'(early), 32'd0);
        chk("mul_hi", bus.hi, 32'hFFFF_FFFE);
        chk("mul_lo", bus.lo, 32'h0000_0001);
        chk("mul_done_pulse", 32'(bus.done), 32'd1);
        @(negedge clk);
        chk("mul_done_clear", 32'(bus.done), 32'd0);

        // DIVU 100/7 with start and mthi thrown at it while busy
        start_op(OP_DIVU, 32'd100, 32'd7);
        chk("div_state", 32'(dbg_state), 32'(DIV));
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.srca  = 32'd2;
        bus.srcb  = 32'd3;
        bus.mthi  = 1'b1;
        bus.wd    = 32'h0000_1234;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        chk("busy_mthi_ignored", bus.hi, 32'hFFFF_FFFE);
        chk("busy_start_state", 32'(dbg_state), 32'(DIV));
        wait_done(cyc, early);
        chk("div_remaining_cycles", 32'(cyc), 32'd28);
        chk("div_lo", bus.lo, 32'd14);
        chk("div_hi", bus.hi, 32'd2);
        chk("div_done_pulse", 32'(bus.done), 32'd1);

        // mthi in the done cycle, then both writes together
        bus.mthi = 1'b1;
        bus.wd   = 32'h0000_1234;
        @(negedge clk);
        bus.mthi = 1'b0;
        chk("mthi_hi", bus.hi, 32'h0000_1234);
        chk("mthi_lo_kept", bus.lo, 32'd14);
        bus.mthi = 1'b1;
        bus.mtlo = 1'b1;
        bus.wd   = 32'hCAFE_F00D;
        @(negedge clk);
        chk("mthilo_hi", bus.hi, 32'hCAFE_F00D);
        chk("mthilo_lo", bus.lo, 32'hCAFE_F00D);

        // start wins over a simultaneous write; DIVU by zero
        bus.wd = 32'h0000_DEAD;
        start_op(OP_DIVU, 32'd5, 32'd0);
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        chk("start_drops_mthi", bus.hi, 32'hCAFE_F00D);
        chk("start_drops_mtlo", bus.lo, 32'hCAFE_F00D);
        wait_done(cyc, early);
        chk("div0_lo", bus.lo, 32'hFFFF_FFFF);
        chk("div0_hi", bus.hi, 32'd5);

`ifdef MDU_SIGNED_EN
        start_op(OP_MULT, 32'hFFFF_FFFD, 32'd4);
        wait_done(cyc, early);
        chk("smul_hi", bus.hi, 32'hFFFF_FFFF);
        chk("smul_lo", bus.lo, 32'hFFFF_FFF4);
        start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc, early);
        chk("sdiv_lo", bus.lo, 32'hFFFF_FFFD);
        chk("sdiv_hi", bus.hi, 32'hFFFF_FFFF);
`else
        start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc, early);
        chk("udiv_lo", bus.lo, 32'h7FFF_FFFC);
        chk("udiv_hi", bus.hi, 32'd1);
`endif

        // Back-to-back start in the done cycle, then reset mid-operation
        start_op(OP_DIVU, 32'd1000, 32'd3);
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_hi", bus.hi, 32'h0);
        chk("midrst_lo", bus.lo, 32'h0);
        chk("midrst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        start_op(OP_MULTU, 32'd6, 32'd7);
        wait_done(cyc, early);
        chk("post_rst_cycles", 32'(cyc), 32'd32);
        chk("post_rst_lo", bus.lo, 32'd42);
        chk("post_rst_hi", bus.hi, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_controller.md
Name: mdu_controller

Overview:
- Sequencer for the multiply/divide unit (MULT/MULTU/DIV/DIVU) and the HI/LO register pair of the pipelined MIPS core.
- Accepts an operation from the EX stage and runs an iterative shift-add multiplier or restoring divider over WIDTH cycles.
- Raises busy so hazard logic stalls MFHI/MFLO/MTHI/MTLO and further mult/div ops.
- Owns HI/LO; serves MFHI/MFLO reads and MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  EX-stage request to begin op.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- srca  in  WIDTH  multiplicand / dividend (rs).
- srcb  in  WIDTH  multiplier / divisor (rt).
- mthi  in  1  write wd to HI.
- mtlo  in  1  write wd to LO.
- wd  in  WIDTH  MTHI/MTLO write data.
- hi  out  WIDTH  HI register (MFHI source).
- lo  out  WIDTH  LO register (MFLO source).
- busy  out  1  op in progress; hazard unit stalls dependents.
- done  out  1  one-cycle pulse after HI/LO take a result.

Behaviour:
- One clock domain, clk. reset is asynchronous and active-high.
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0, internal accumulators=0.
- States: IDLE, MUL, DIV.
- IDLE→MUL: start=1 and op[1]=0. IDLE→DIV: start=1 and op[1]=1.
- At the accepting edge E0, operands load into work registers (magnitudes if signed; see Optional Feature), counter clears, and busy goes 1.
- MUL step, edges E1..E_WIDTH: if multiplier LSB is 1, add multiplicand to the upper accumulator half (carry kept); then shift the {carry, acc} pair right by 1.
- DIV step, edges E1..E_WIDTH: shift {rem, quo} left by 1; trial subtract divisor from rem (WIDTH+1 bits). If non-negative, keep the difference and set quo LSB=1; otherwise restore rem and set quo LSB=0.
- At edge E_WIDTH (counter = WIDTH-1):
  - Write the result: MUL gives hi=product[2W-1:W], lo=product[W-1:0]; DIV gives lo=quotient, hi=remainder.
  - busy→0, state→IDLE, done=1 for the following cycle.
- Latency: result visible in hi/lo exactly WIDTH cycles after the accepting edge. busy is high for WIDTH cycles.
- Back-to-back: start may be accepted in the cycle done=1.
- start while busy: ignored, no queueing. The hazard unit must hold the instruction.
- mthi/mtlo while IDLE: hi/lo take wd at the next edge. Both may be asserted together.
- mthi/mtlo while busy: ignored.
- start together with mthi/mtlo in IDLE: start wins; the write is dropped.
- Divide by zero is not trapped and completes normally. Unsigned result: lo=all ones, hi=dividend.
- Multiply overflow: not applicable; the full 2W product is kept.
- reset mid-operation: aborts immediately to reset values; no partial write to hi/lo.

Optional Feature:
- Macro: MDU_SIGNED_EN.
- Defined:
  - MULT/DIV take the absolute value of each operand at E0 and latch the sign flags.
  - At the result write, the product is negated if the signs differ.
  - The quotient is negated if the signs differ; the remainder takes the dividend's sign.
  - Signed divide by zero writes the raw unsigned-core result, with no correction applied.
- Undefined: op[0] is ignored; MULT/DIV behave as MULTU/DIVU, and no sign logic is synthesized.

Decomposition:
- Package mdu_pkg:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
  - state enum (IDLE, MUL, DIV).
  - WIDTH default constant.
- One natural sub-module: mdu_sign_fix. It is combinational: two's-complement absolute value on input and conditional negation of the 2W result on output. It is instantiated only under MDU_SIGNED_EN.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 32 cycles hi=0xFFFFFFFE, lo=0x00000001. busy high for exactly 32 cycles; single done pulse.
- DIVU 100 / 7 → lo=14, hi=2. Then DIVU 5 / 0 → lo=0xFFFFFFFF, hi=5.
- With MDU_SIGNED_EN:
  - MULT -3 × 4 → hi=0xFFFFFFFF, lo=0xFFFFFFF4.
  - DIV -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Without MDU_SIGNED_EN: DIV 0xFFFFFFF9 / 2 → lo=0x7FFFFFFC, hi=1.
- While busy:
  - start with MULTU 2×3 → ignored; original result unchanged.
  - mthi wd=0x1234 → ignored.
  - After done: mthi wd=0x1234 → hi=0x00001234 next cycle.
- Start DIVU 1000/3, assert reset at cycle 10 → busy=0, hi=lo=0 immediately. A fresh MULTU 6×7 then yields lo=42, hi=0.
